uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Parametrised, oversampling UART receiver; next generation of the team's basic UART Rx.
//  Runs entirely in the clk domain, no derived clocks. Adds configurable data bits, parity, stop bits,
//  mid-bit sampling, start-glitch rejection, parity/framing/overrun errors and a valid/ready output.
//  Sits between the board rx pin and a byte FIFO or command parser.
// PARAMETERS
//  CLK_FREQ    50_000_000  clk frequency, Hz
//  BAUD        115200      line rate, bit/s
//  OVERSAMPLE  16          ticks per bit; even, >=8
//  DATA_BITS   8           payload bits, 5..9, LSB first on the line
//  PARITY      0           0 none, 1 even, 2 odd
//  STOP_BITS   1           1 or 2
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          reset
//  rx          in   1          asynchronous serial line, idle high
//  rx_data     out  DATA_BITS  received payload, valid while rx_valid
//  rx_valid    out  1          frame available
//  rx_ready    in   1          consumer accepts frame when rx_valid&&rx_ready
//  parity_err  out  1          frame qualifier: parity mismatch (0 if PARITY==0)
//  frame_err   out  1          frame qualifier: a stop bit sampled 0
//  overrun     out  1          1-cycle pulse: completed frame dropped
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  Reset: rst_n is synchronous, active-low on clk. Reset values: rx_data=0, rx_valid=0,
//   parity_err=0, frame_err=0, overrun=0, busy=0. Sync flops reset to 1; state=IDLE; counters=0;
//   armed=0. Reset mid-frame discards the frame with no output.
//  rx passes through 2-FF synchroniser -> rx_s. All decisions use rx_s.
//  Tick: DIV=CLK_FREQ/(BAUD*OVERSAMPLE), integer truncated, must be >=1.
//   Free-running counter 0..DIV-1; tick high 1 cycle at DIV-1. FSM acts only on tick cycles.
//  armed flag: set when rx_s==1 on a tick; cleared on leaving IDLE.
//   Prevents a held-low line (break) from retriggering.
//  FSM (os_cnt 0..OVERSAMPLE-1, bit_cnt 0..DATA_BITS-1):
//   IDLE:   armed && rx_s==0 -> START, os_cnt=0.
//   START:  at os_cnt==OVERSAMPLE/2-1: rx_s==1 -> IDLE (glitch, no output);
//           else os_cnt=0 -> DATA.
//   DATA:   at os_cnt==OVERSAMPLE-1 (bit centre) shift rx_s in LSB-first, os_cnt=0.
//           After bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
//   PARITY: sample at centre; perr = ^data ^ rx_s, inverted for odd. -> STOP.
//   STOP:   sample each stop bit at centre; any 0 sets ferr.
//           After last stop sample -> IDLE (half bit early, allows resync).
//  Completion: on the cycle after the tick sampling the final stop bit:
//   - rx_valid==0, or rx_valid&&rx_ready in the same cycle: load rx_data/parity_err/frame_err;
//     rx_valid=1; no overrun.
//   - rx_valid&&!rx_ready: new frame dropped, held frame unchanged, overrun=1 one cycle.
//  Handshake: rx_valid and qualifiers stay stable until accepted; rx_valid clears the cycle after
//   rx_valid&&rx_ready unless a new frame loads that same cycle.
//  Errored frames are still delivered; consumer decides. Break (rx low > 1 frame):
//   one frame, data=0, frame_err=1, then no further frames until rx_s returns high.
//  Latency: first bit edge to rx_valid ~ (1+DATA_BITS+P+STOP_BITS-0.5) bit times + 3 clk.
// STRUCTURE
//  Package uart_pkg: parity encodings (PAR_NONE/EVEN/ODD), FSM state localparams (3 bits),
//   function uart_div(clk_freq, baud, os), elaboration checks (DIV>=1, OVERSAMPLE even >=8).
//  Sub-module uart_baud_tick (params DIV; clk, rst_n -> tick); reused later by uart_tx_os.
// TESTING (CLK_FREQ=7_372_800, BAUD=115200, OVERSAMPLE=16 -> DIV=4, 64 clk/bit)
//  8N1 0xA5, rx_ready=1: rx_data=0xA5, rx_valid high 1 cycle, no errors, busy low after frame.
//  PARITY=1, 8E1 0x3C with wrong parity bit: rx_data=0x3C, parity_err=1;
//   correct parity: parity_err=0.
//  Stop bit driven 0 on 0x55: frame_err=1. rx held low 2 frames: exactly one frame, 0x00,
//   frame_err=1; then a 0x12 frame after line high: 0x12, no errors.
//  20-clk low glitch on idle line: no rx_valid, FSM back in IDLE before 64 clk.
//  rx_ready=0, send 0x11 then 0x22: rx_data stays 0x11, overrun pulses once; rx_ready=1 takes 0x11.
//  rst_n low 3 cycles mid-data of 0x77: outputs at reset values, next frame 0x0F received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states, baud divider
// helper and a configuration sanity check used at elaboration.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

    function automatic bit uart_cfg_ok(input int div, input int os, input int data_bits,
                                       input int parity, input int stop_bits);
        return (div >= 1) && (os >= 8) && (os % 2 == 0) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
               (stop_bits == 1 || stop_bits == 2);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, start-glitch rejection,
// parity/framing/overrun reporting and a valid/ready output port.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [OSW-1:0] OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);

    if (!uart_cfg_ok(DIV, OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS)) begin : g_cfg_err
        $error("uart_rx_os: unsupported parameter combination");
    end

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    rx_state_e              state_q, state_d;
    logic                   rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [OSW-1:0]         os_cnt_q, os_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic                   armed_q, armed_d, done_q, done_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   centre;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_IDLE:   if (armed_q && !rx_s_q) state_d = ST_START;
                ST_START:  if (os_cnt_q == OS_HALF) state_d = rx_s_q ? ST_IDLE : ST_DATA;
                ST_DATA:   if (os_cnt_q == OS_LAST && bit_cnt_q == BIT_LAST)
                               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                ST_PARITY: if (os_cnt_q == OS_LAST) state_d = ST_STOP;
                ST_STOP:   if (os_cnt_q == OS_LAST && bit_cnt_q == STOP_LAST) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Sampling datapath; the last stop sample returns to IDLE mid-bit so the next start edge is caught early.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        armed_d   = armed_q;
        done_d    = 1'b0;
        centre    = (os_cnt_q == OS_LAST);
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                ST_START: begin
                    os_cnt_d = (os_cnt_q == OS_HALF) ? '0 : os_cnt_q + OSW'(1);
                end
                ST_DATA: begin
                    os_cnt_d = centre ? '0 : os_cnt_q + OSW'(1);
                    if (centre) begin
                        shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
                    end
                end
                ST_PARITY: begin
                    os_cnt_d = centre ? '0 : os_cnt_q + OSW'(1);
                    if (centre) perr_d = (^shreg_q) ^ rx_s_q ^ (PARITY == PAR_ODD);
                end
                ST_STOP: begin
                    os_cnt_d = centre ? '0 : os_cnt_q + OSW'(1);
                    if (centre) begin
                        if (!rx_s_q) ferr_d = 1'b1;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: os_cnt_d = '0;
            endcase
        end
    end

    // Output port: a held frame is never overwritten; a frame completing against it is dropped.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                parity_err_d = perr_q;
                frame_err_d  = ferr_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
